// File: rtl/ifns_23di_pkg.sv
// Shared constants for the 23-bit IFNS decoder: bus widths, Fibonacci weight table and FSM states.
// The optional range check is enabled by defining IFNS_DEC_RANGE_CHK_EN.
package ifns_23di_pkg;

  localparam int CW_W  = 33;
  localparam int DW    = 23;
  localparam int ACC_W = 24;

  // W_1..W_32 = Fib(1)..Fib(32); W_33 skips Fib(33) and takes Fib(34)
  localparam logic [ACC_W-1:0] IFNS_W [1:33] = '{
    24'd1,       24'd1,       24'd2,       24'd3,       24'd5,
    24'd8,       24'd13,      24'd21,      24'd34,      24'd55,
    24'd89,      24'd144,     24'd233,     24'd377,     24'd610,
    24'd987,     24'd1597,    24'd2584,    24'd4181,    24'd6765,
    24'd10946,   24'd17711,   24'd28657,   24'd46368,   24'd75025,
    24'd121393,  24'd196418,  24'd317811,  24'd514229,  24'd832040,
    24'd1346269, 24'd2178309, 24'd5702887
  };

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Positions past d33 (possible on the last beat) weigh nothing
  function automatic logic [ACC_W-1:0] ifns_weight(input int idx);
    if (idx >= 1 && idx <= CW_W) return IFNS_W[idx];
    return '0;
  endfunction

endpackage

// File: rtl/ifns_dec_slice.sv
// Combinational BPC-bit weighted adder: sums the weights of the set bits of one beat's slice.
module ifns_dec_slice
  import ifns_23di_pkg::*;
#(
  parameter int BPC    = 11,
  parameter int BEAT_W = 6
) (
  input  logic [BEAT_W-1:0] beat,
  input  logic [BPC-1:0]    bits,
  output logic [ACC_W-1:0]  sum
);

  // Bit j of beat b is codeword bit d_(b*BPC + j + 1)
  always_comb begin
    sum = '0;
    for (int j = 0; j < BPC; j++) begin
      if (bits[j]) sum = sum + ifns_weight(int'(beat) * BPC + j + 1);
    end
  end

endmodule

// File: rtl/ifns_decoder_23di_seq.sv
// Multi-cycle IFNS decoder: folds the 33-bit weighted sum over N = ceil(33/BPC) beats.
// Define IFNS_DEC_RANGE_CHK_EN to add the out_err port flagging sums >= 2^23.
module ifns_decoder_23di_seq
  import ifns_23di_pkg::*;
#(
  parameter int BPC = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW_W-1:0] d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   v
`ifdef IFNS_DEC_RANGE_CHK_EN
  ,
  output logic            out_err
`endif
);

  localparam int N      = (CW_W + BPC - 1) / BPC;
  localparam int BEAT_W = 6;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  logic [1:0]        state_q, state_d;
  logic [CW_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ACC_W-1:0]  slice_sum;

  ifns_dec_slice #(
    .BPC    (BPC),
    .BEAT_W (BEAT_W)
  ) u_slice (
    .beat (beat_q),
    .bits (sr_q[BPC-1:0]),
    .sum  (slice_sum)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = d;
          acc_d   = '0;
          beat_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d  = acc_q + slice_sum;
        sr_d   = sr_q >> BPC;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign v         = out_valid ? acc_q[DW-1:0] : '0;

`ifdef IFNS_DEC_RANGE_CHK_EN
  assign out_err = out_valid & acc_q[ACC_W-1];
`else
  // Without the range check the sum's top bit is deliberately dropped
  logic unused_acc_msb;
  assign unused_acc_msb = acc_q[ACC_W-1];
`endif

endmodule

// File: tb/tb_ifns_decoder_23di_seq.sv
// Directed and round-trip bench for the IFNS decoder (default BPC = 11, so out_valid in cycle k+4).
module tb_ifns_decoder_23di_seq;
  import ifns_23di_pkg::*;

  localparam int BPC     = 11;
  localparam int EXP_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] v;
`ifdef IFNS_DEC_RANGE_CHK_EN
  logic        out_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifns_decoder_23di_seq #(.BPC(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v         (v)
`ifdef IFNS_DEC_RANGE_CHK_EN
    ,
    .out_err   (out_err)
`endif
  );

  typedef struct {
    logic [32:0] d;
    logic [22:0] v;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Handshake one codeword, then count cycles until out_valid (bounded)
  task automatic applyStimulus(input logic [32:0] dv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    d        = dv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    d        = ~dv;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Greedy Fibonacci encoding from the top weight down always terminates at zero here
  function automatic logic [32:0] encode(input int unsigned val);
    logic [32:0] cw;
    int unsigned rem;
    cw  = '0;
    rem = val;
    for (int i = 33; i >= 1; i--) begin
      if (int'(IFNS_W[i]) <= int'(rem)) begin
        cw[i-1] = 1'b1;
        rem     = rem - int'(IFNS_W[i]);
      end
    end
    return cw;
  endfunction

  initial begin
    int lat;
    int unsigned val;

    vecs[0] = '{33'h1_0000_0000, 23'd5702887, 1'b0};
    vecs[1] = '{33'h0_0000_0003, 23'd2,       1'b0};
    vecs[2] = '{33'h0_0000_0004, 23'd2,       1'b0};
    vecs[3] = '{33'h0_0000_0000, 23'd0,       1'b0};
    vecs[4] = '{33'h1_FFFF_FFFF, 23'd3017165, 1'b1};
    vecs[5] = '{33'h0_8000_0000, 23'd2178309, 1'b0};
    vecs[6] = '{33'h0_0000_07FF, 23'd232,     1'b0};
    vecs[7] = '{33'h1_C000_0000, 23'd838857,  1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_v", 32'(v), 32'd0);
`ifdef IFNS_DEC_RANGE_CHK_EN
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].d, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(EXP_LAT));
      checkOutput($sformatf("vec%0d_v", i), 32'(v), 32'(vecs[i].v));
`ifdef IFNS_DEC_RANGE_CHK_EN
      checkOutput($sformatf("vec%0d_out_err", i), 32'(out_err), 32'(vecs[i].err));
`endif
      releaseOutput();
      checkOutput($sformatf("vec%0d_out_valid_drop", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d_in_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Reset two cycles after accept discards the partial sum
    in_valid = 1'b1;
    d        = 33'h1_FFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midacc_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midacc_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(33'h0_0000_0004, lat);
    checkOutput("after_rst_latency", 32'(lat), 32'(EXP_LAT));
    checkOutput("after_rst_v", 32'(v), 32'd2);
    releaseOutput();

    // Backpressure in DONE with stray in_valid pulses
    applyStimulus(33'h1_0000_0000, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      d        = 33'h0_0000_07FF;
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d_v", c), 32'(v), 32'd5702887);
      checkOutput($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    releaseOutput();
    checkOutput("bp_out_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_no_capture", 32'(in_ready), 32'd1);

    // Round trip through a reference encoder with random gaps
    for (int t = 0; t < 300; t++) begin
      val = $urandom_range(0, 8388607);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      applyStimulus(encode(val), lat);
      checkOutput($sformatf("rt%0d_latency", t), 32'(lat), 32'(EXP_LAT));
      checkOutput($sformatf("rt%0d_v", t), 32'(v), val);
`ifdef IFNS_DEC_RANGE_CHK_EN
      checkOutput($sformatf("rt%0d_out_err", t), 32'(out_err), 32'd0);
`endif
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      releaseOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
